// File: rtl/accum_ctrl.sv
// Frame controller for an external complex accumulator: frames elements, tags frames, returns results in order.
// Accumulator-side outputs are combinational; the result path has a single capture register.
package accum_ctrl_pkg;
  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;
endpackage

module accum_ctrl
  import accum_ctrl_pkg::*;
#(
  parameter int LEN_W     = 16,
  parameter int TAG_DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [LEN_W-1:0] i_cfg_len,
  input  logic             i_cfg_load,
  input  logic             i_in_valid,
  input  complex_t         i_in_data,
  output logic             o_in_ready,
  output complex_t         o_acc_in,
  output logic             o_acc_start,
  output logic             o_acc_stop,
  input  logic             i_acc_valid,
  input  complex_t         i_acc_out,
  output logic             o_res_valid,
  output complex_t         o_res_data,
  output logic [7:0]       o_res_tag,
  output logic             o_busy,
  output logic             o_err_cfg
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = $clog2(TAG_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READY, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [LEN_W-1:0] r_len, r_pend_len, r_cnt, w_cnt_inc;
  logic             r_pend_vld;
  logic [7:0]       r_seq;
  logic [CNT_W-1:0] r_inflight;
  logic [7:0]       r_tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic             r_err;
  logic             r_res_valid;
  complex_t         r_res_data;
  logic [7:0]       r_res_tag;
  logic             w_ready, w_accept, w_cfg_ok, w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(TAG_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Reset gates acceptance so a frame cut by reset never emits a stop.
  assign w_ready   = !i_reset && (r_state != S_IDLE) && (r_inflight < CNT_W'(TAG_DEPTH));
  assign w_accept  = i_in_valid && w_ready;
  assign w_cfg_ok  = i_cfg_load && (i_cfg_len >= LEN_W'(12));
  assign w_pop     = i_acc_valid && (r_inflight != '0);
  assign w_cnt_inc = r_cnt + LEN_W'(1);

  always_comb begin
    w_state_nxt = r_state;
    o_acc_start = 1'b0;
    o_acc_stop  = 1'b0;
    o_acc_in    = '0;
    if (w_accept) o_acc_in = i_in_data;
    case (r_state)
      S_IDLE:  if (w_cfg_ok) w_state_nxt = S_READY;
      S_READY: if (w_accept) begin
        o_acc_start = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN:   if (w_accept && (w_cnt_inc == r_len)) begin
        o_acc_stop  = 1'b1;
        w_state_nxt = S_READY;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_pend_len  <= '0;
      r_pend_vld  <= 1'b0;
      r_cnt       <= '0;
      r_seq       <= '0;
      r_inflight  <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_err       <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_acc_start)   r_cnt <= LEN_W'(1);
      else if (w_accept) r_cnt <= w_cnt_inc;
      if (i_cfg_load && !w_cfg_ok) r_err <= 1'b1;
      // A load arriving mid-frame waits; the closing frame keeps its own length.
      if (w_cfg_ok && (r_state == S_RUN) && !o_acc_stop) begin
        r_pend_len <= i_cfg_len;
        r_pend_vld <= 1'b1;
      end else if (w_cfg_ok) begin
        r_len      <= i_cfg_len;
        r_pend_vld <= 1'b0;
      end else if (o_acc_stop && r_pend_vld) begin
        r_len      <= r_pend_len;
        r_pend_vld <= 1'b0;
      end
      if (o_acc_stop) begin
        r_seq    <= r_seq + 8'd1;
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      r_res_valid <= w_pop;
      if (w_pop) begin
        r_res_data <= i_acc_out;
        r_res_tag  <= r_tag_mem[r_rd_ptr];
        r_rd_ptr   <= ptr_inc(r_rd_ptr);
      end
      if (o_acc_stop && !w_pop)      r_inflight <= r_inflight + CNT_W'(1);
      else if (!o_acc_stop && w_pop) r_inflight <= r_inflight - CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (o_acc_stop) r_tag_mem[r_wr_ptr] <= r_seq;
  end

  assign o_in_ready  = w_ready;
  assign o_res_valid = r_res_valid;
  assign o_res_data  = r_res_data;
  assign o_res_tag   = r_res_tag;
  assign o_busy      = (r_state == S_RUN) || (r_inflight != '0);
  assign o_err_cfg   = r_err;

endmodule

// File: tb/tb_accum_ctrl.sv
// Bench for accum_ctrl: an accumulator stand-in with 52-cycle latency, a frame-level reference model
// checked every cycle, and directed scenarios with hand-computed expectations.
module tb_accum_ctrl;
  import accum_ctrl_pkg::*;

  typedef struct {int re; int im; int due;} acc_ent_t;
  typedef struct {int re; int im; int tag;} res_ent_t;
  typedef struct {int cyc; int re; int im; int tag;} log_ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] cfg_len = '0;
  logic        cfg_load = 1'b0;
  logic        in_valid = 1'b0;
  complex_t    in_data = '0;
  logic        in_ready;
  complex_t    acc_in;
  logic        acc_start, acc_stop;
  logic        acc_valid = 1'b0;
  complex_t    acc_out = '0;
  logic        res_valid;
  complex_t    res_data;
  logic [7:0]  res_tag;
  logic        busy, err_cfg;

  accum_ctrl #(.LEN_W(16), .TAG_DEPTH(8)) dut (
    .i_clk(clk), .i_reset(reset), .i_cfg_len(cfg_len), .i_cfg_load(cfg_load),
    .i_in_valid(in_valid), .i_in_data(in_data), .o_in_ready(in_ready),
    .o_acc_in(acc_in), .o_acc_start(acc_start), .o_acc_stop(acc_stop),
    .i_acc_valid(acc_valid), .i_acc_out(acc_out),
    .o_res_valid(res_valid), .o_res_data(res_data), .o_res_tag(res_tag),
    .o_busy(busy), .o_err_cfg(err_cfg)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  bit chk_on = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // Accumulator stand-in: sums acc_in from start through stop, answers 52 cycles after stop.
  acc_ent_t env_q[$];
  int  env_re = 0, env_im = 0;
  bit  env_hold = 0;
  bit  inj_vld = 0;
  complex_t inj_dat = '0;

  initial forever begin
    @(negedge clk);
    if (reset) begin
      env_q.delete();
      env_re = 0;
      env_im = 0;
    end else begin
      if (acc_start) begin
        env_re = int'(acc_in.re);
        env_im = int'(acc_in.im);
      end else begin
        env_re += int'(acc_in.re);
        env_im += int'(acc_in.im);
      end
      if (acc_stop) env_q.push_back('{env_re, env_im, cyc + 52});
    end
  end

  initial forever begin
    @(posedge clk);
    #2;
    acc_valid = 1'b0;
    acc_out   = '0;
    if (inj_vld) begin
      acc_valid = 1'b1;
      acc_out   = inj_dat;
    end else if (!env_hold && env_q.size() > 0 && env_q[0].due <= cyc) begin
      acc_valid  = 1'b1;
      acc_out.re = 16'(env_q[0].re);
      acc_out.im = 16'(env_q[0].im);
      void'(env_q.pop_front());
    end
  end

  // Reference model: frame bookkeeping in plain integers, results in a FIFO of expected sums/tags.
  bit  m_loaded = 0, m_open = 0, m_pend_vld = 0, m_err = 0, m_rv = 0;
  int  m_len = 0, m_pend_len = 0, m_cnt = 0, m_sre = 0, m_sim = 0, m_seq = 0, m_infl = 0;
  int  m_rre = 0, m_rim = 0, m_rtag = 0;
  res_ent_t exp_q[$];
  int       start_log[$];
  int       stop_log[$];
  log_ent_t res_log[$];

  initial forever begin
    bit e_rdy, e_acc, e_start, e_stop;
    complex_t e_ain, e_rd;
    res_ent_t r;
    @(negedge clk);
    e_rdy   = !reset && m_loaded && (m_infl < 8);
    e_acc   = in_valid && e_rdy;
    e_start = e_acc && !m_open;
    e_stop  = e_acc && m_open && (m_cnt + 1 == m_len);
    e_ain   = e_acc ? in_data : '0;
    e_rd.re = 16'(m_rre);
    e_rd.im = 16'(m_rim);
    if (chk_on) begin
      chk("in_ready", in_ready, e_rdy);
      chk("acc_start", acc_start, e_start);
      chk("acc_stop", acc_stop, e_stop);
      chk("acc_in", acc_in, e_ain);
      chk("busy", busy, m_open || (m_infl > 0));
      chk("err_cfg", err_cfg, m_err);
      chk("res_valid", res_valid, m_rv);
      if (m_rv) begin
        chk("res_data", res_data, e_rd);
        chk("res_tag", res_tag, m_rtag);
      end
      if (acc_start) start_log.push_back(cyc);
      if (acc_stop) stop_log.push_back(cyc);
      if (res_valid) res_log.push_back('{cyc, int'(res_data.re), int'(res_data.im), int'(res_tag)});
    end
    if (reset) begin
      m_loaded = 0; m_open = 0; m_pend_vld = 0; m_err = 0; m_rv = 0;
      m_cnt = 0; m_seq = 0; m_infl = 0; m_rre = 0; m_rim = 0; m_rtag = 0;
      exp_q.delete();
    end else begin
      m_rv = 0;
      if (acc_valid && m_infl > 0) begin
        r = exp_q.pop_front();
        m_rv = 1; m_rre = r.re; m_rim = r.im; m_rtag = r.tag;
        m_infl--;
      end
      if (e_acc) begin
        if (!m_open) begin
          m_open = 1; m_cnt = 1;
          m_sre = int'(in_data.re); m_sim = int'(in_data.im);
        end else begin
          m_cnt++;
          m_sre += int'(in_data.re); m_sim += int'(in_data.im);
          if (m_cnt == m_len) begin
            exp_q.push_back('{m_sre, m_sim, m_seq});
            m_seq = (m_seq + 1) % 256;
            m_infl++;
            m_open = 0;
            if (m_pend_vld) begin m_len = m_pend_len; m_pend_vld = 0; end
          end
        end
      end
      if (cfg_load) begin
        if (cfg_len < 12) m_err = 1;
        else if (m_open) begin m_pend_vld = 1; m_pend_len = int'(cfg_len); end
        else begin m_len = int'(cfg_len); m_loaded = 1; m_pend_vld = 0; end
      end
    end
  end

  task automatic cyc_end();
    @(posedge clk);
    #1;
    cfg_load = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
  endtask

  task automatic clear_logs();
    start_log.delete();
    stop_log.delete();
    res_log.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    cyc_end();
    cyc_end();
    reset = 1'b0;
    clear_logs();
  endtask

  task automatic do_load(input int len);
    cfg_len  = 16'(len);
    cfg_load = 1'b1;
    cyc_end();
  endtask

  task automatic send(input int re, input int im);
    in_valid   = 1'b1;
    in_data.re = 16'(re);
    in_data.im = 16'(im);
    cyc_end();
  endtask

  task automatic wait_res(input int n, input int budget, input string nm);
    int k = 0;
    while (res_log.size() < n && k < budget) begin
      cyc_end();
      k++;
    end
    chk(nm, res_log.size(), n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int first_low, first_high;
    repeat (2) @(posedge clk);
    #1;
    chk_on = 1;

    // Single frame of 12 x (1+0i).
    apply_reset();
    do_load(12);
    repeat (2) cyc_end();
    for (int k = 0; k < 12; k++) send(1, 0);
    wait_res(1, 80, "t1_count");
    chk("t1_frame_span", stop_log[0] - start_log[0], 11);
    chk("t1_latency", res_log[0].cyc - stop_log[0], 53);
    chk("t1_re", res_log[0].re, 12);
    chk("t1_im", res_log[0].im, 0);
    chk("t1_tag", res_log[0].tag, 0);

    // Three back-to-back frames of k+ki, k=1..16.
    apply_reset();
    do_load(16);
    for (int f = 0; f < 3; f++)
      for (int k = 1; k <= 16; k++) send(k, k);
    wait_res(3, 120, "t2_count");
    chk("t2_b2b_start", start_log[1] - stop_log[0], 1);
    for (int i = 0; i < 3; i++) begin
      chk("t2_re", res_log[i].re, 136);
      chk("t2_im", res_log[i].im, 136);
      chk("t2_tag", res_log[i].tag, i);
    end
    chk("t2_gap01", res_log[1].cyc - res_log[0].cyc, 16);
    chk("t2_gap12", res_log[2].cyc - res_log[1].cyc, 16);

    // Mid-frame gap of 5 cycles; a length change during the gap takes effect on the next frame.
    apply_reset();
    do_load(12);
    for (int k = 1; k <= 6; k++) send(k, -k);
    repeat (2) cyc_end();
    do_load(13);
    repeat (2) cyc_end();
    for (int k = 7; k <= 12; k++) send(k, -k);
    for (int k = 0; k < 13; k++) send(1, 1);
    wait_res(2, 120, "t3_count");
    chk("t3_span0", stop_log[0] - start_log[0], 16);
    chk("t3_re0", res_log[0].re, 78);
    chk("t3_im0", res_log[0].im, -78);
    chk("t3_span1", stop_log[1] - start_log[1], 12);
    chk("t3_re1", res_log[1].re, 13);
    chk("t3_tag1", res_log[1].tag, 1);

    // Bad length, stray accumulator result, then good length.
    apply_reset();
    inj_dat.re = 16'sd7;
    inj_dat.im = 16'sd7;
    inj_vld = 1;
    cyc_end();
    inj_vld = 0;
    repeat (3) cyc_end();
    chk("t4_stray_res", res_log.size(), 0);
    do_load(5);
    chk("t4_err_bad", err_cfg, 1);
    chk("t4_rdy_bad", in_ready, 0);
    do_load(12);
    chk("t4_rdy_good", in_ready, 1);
    chk("t4_err_sticky", err_cfg, 1);

    // Tag FIFO fills with results withheld; released results re-open input.
    apply_reset();
    env_hold = 1;
    do_load(12);
    first_low = -1;
    first_high = -1;
    for (int i = 0; i < 140; i++) begin
      if (i == 120) env_hold = 0;
      if (!in_ready && first_low < 0) first_low = i;
      if (in_ready && first_low >= 0 && first_high < 0) first_high = i;
      send(1, 0);
    end
    chk("t5_ready_drop", first_low, 96);
    chk("t5_ready_rise", first_high, 121);
    wait_res(8, 60, "t5_count");
    for (int i = 0; i < 8; i++) begin
      chk("t5_tag", res_log[i].tag, i);
      chk("t5_re", res_log[i].re, 12);
    end

    // Reset at element 6 of a frame.
    apply_reset();
    do_load(12);
    for (int k = 0; k < 5; k++) send(2, 3);
    in_valid = 1'b1;
    in_data.re = 16'sd2;
    in_data.im = 16'sd3;
    reset = 1'b1;
    cyc_end();
    reset = 1'b0;
    clear_logs();
    chk("t6_in_ready", in_ready, 0);
    chk("t6_acc_start", acc_start, 0);
    chk("t6_acc_stop", acc_stop, 0);
    chk("t6_acc_in", acc_in, 0);
    chk("t6_res_valid", res_valid, 0);
    chk("t6_res_data", res_data, 0);
    chk("t6_res_tag", res_tag, 0);
    chk("t6_busy", busy, 0);
    chk("t6_err", err_cfg, 0);
    for (int k = 0; k < 70; k++) send(2, 3);
    chk("t6_no_stop", stop_log.size(), 0);
    chk("t6_no_res", res_log.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
